// File: rtl/instr_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // Word-align a byte PC; the low two bits are ignored by the core.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ROM, redirect and decode-side signals of the fetch stage.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ADDR_DEPTH = 10
);

    logic                  rom_enable;
    logic [ADDR_DEPTH-1:0] rom_addr;
    logic [WORD_SIZE-1:0]  rom_data;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [WORD_SIZE-1:0]  instr;
    logic [XLEN-1:0]       instr_pc;

    modport master (
        output rom_enable, rom_addr, instr_valid, instr, instr_pc,
        input  rom_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  rom_enable, rom_addr, instr_valid, instr, instr_pc,
        output rom_data, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO with flush; head reads as zero while empty.
module instr_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop & (count != '0);
    assign head   = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !do_pop && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues ROM reads against buffer credits, and
// hands words to decode; a redirect flushes buffered and in-flight fetches.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     WORD_SIZE  = 32,
    parameter int unsigned     ADDR_DEPTH = 10,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int unsigned ENTRY_W = XLEN + WORD_SIZE;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned USED_W  = CNT_W + 1;

    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    inflight_pc;
    logic               inflight;
    logic               started;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic [USED_W-1:0]  used;
    logic               pop;
    logic               push;
    logic               issue;

    // Credits: buffered words plus the returning read, minus this cycle's pop.
    always_comb begin
        pop   = bus.instr_valid & bus.instr_ready;
        used  = USED_W'(count) + USED_W'(inflight) - USED_W'(pop);
        issue = started & ~bus.redirect_valid & (used < USED_W'(FIFO_DEPTH));
        push  = inflight & ~bus.redirect_valid;
    end

    assign bus.rom_enable  = issue;
    assign bus.rom_addr    = pc[ADDR_DEPTH+1:2];
    assign bus.instr_valid = (count != '0);
    assign bus.instr_pc    = head[ENTRY_W-1 -: XLEN];
    assign bus.instr       = head[WORD_SIZE-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            started     <= 1'b0;
        end else begin
            started  <= 1'b1;
            inflight <= issue;
            if (bus.redirect_valid) begin
                pc <= align_pc(bus.redirect_pc);
            end else if (issue) begin
                pc          <= pc + XLEN'(INSTR_BYTES);
                inflight_pc <= pc;
            end
        end
    end

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({inflight_pc, bus.rom_data}),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing scenarios plus a random run checked
// against an in-order program-counter stream model.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int unsigned WS = 32;
    localparam int unsigned AD = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.WORD_SIZE(WS), .ADDR_DEPTH(AD)) bus ();

    instr_fetch #(
        .WORD_SIZE  (WS),
        .ADDR_DEPTH (AD),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous ROM: word i holds A000_0000 + i, data held when not enabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rom_data <= NOP_INSTR;
        else if (bus.rom_enable) bus.rom_data <= 32'hA000_0000 + 32'(bus.rom_addr);
    end

    int total = 0;
    int bad = 0;
    logic [31:0] exp_pc;
    int gap, max_gap, stall_run;
    logic s_valid, s_en;
    logic [31:0] s_instr, s_pc;
    logic [AD-1:0] s_addr;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'hA000_0000 + ((pc >> 2) % 32'd1024);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, sample, then advance the stream model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        s_valid = bus.instr_valid;
        s_instr = bus.instr;
        s_pc    = bus.instr_pc;
        s_en    = bus.rom_enable;
        s_addr  = bus.rom_addr;
        if (s_valid) begin
            chk("head_pc", 64'(s_pc), 64'(exp_pc));
            chk("head_instr", 64'(s_instr), 64'(rom_word(exp_pc)));
        end
        if (rv) chk("redir_no_fetch", 64'(s_en), 64'(0));
        if (!rdy && !rv) stall_run++; else stall_run = 0;
        if (stall_run >= 3) chk("stall_bound", 64'(s_en), 64'(0));
        if (s_valid && rdy) exp_pc = exp_pc + 32'd4;
        if (rv) exp_pc = {rpc[31:2], 2'b00};
        if (rv || s_valid) gap = 0; else gap++;
        if (gap > max_gap) max_gap = gap;
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", 64'(bus.instr_valid), 64'(0));
        chk("rst_instr", 64'(bus.instr), 64'(0));
        chk("rst_pc", 64'(bus.instr_pc), 64'(0));
        chk("rst_en", 64'(bus.rom_enable), 64'(0));
        chk("rst_addr", 64'(bus.rom_addr), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        exp_pc    = 32'h0;
        gap       = 0;
        max_gap   = 0;
        stall_run = 0;
    endtask

    task automatic measure_latency(input string tag);
        int first;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, '0);
            if (i == 1) begin
                chk({tag, "_first_en"}, 64'(s_en), 64'(1));
                chk({tag, "_first_addr"}, 64'(s_addr), 64'(0));
            end
            if (s_valid) begin
                first = i;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(first), 64'(3));
    endtask

    initial begin
        int issues, stall_en;
        logic rdy, rv;
        logic [31:0] rpc;

        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        exp_pc = 32'h0; gap = 0; max_gap = 0; stall_run = 0;
        #1;
        check_reset_outputs();

        // Startup latency and bubble-free streaming.
        do_reset();
        measure_latency("start");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0);
            chk("stream_valid", 64'(s_valid), 64'(1));
        end

        // Decode stalls: exactly two words buffered, resume in the pop cycle.
        do_reset();
        issues = 0;
        stall_en = 0;
        repeat (2) begin
            step(1'b1, 1'b0, '0);
            if (s_en) issues++;
        end
        repeat (5) begin
            step(1'b0, 1'b0, '0);
            if (s_en) begin issues++; stall_en++; end
            chk("stall_valid", 64'(s_valid), 64'(1));
        end
        chk("stall_fetch", 64'(stall_en), 64'(0));
        chk("buffered", 64'(issues), 64'(2));
        step(1'b1, 1'b0, '0);
        chk("resume_fetch", 64'(s_en), 64'(1));
        repeat (5) begin
            step(1'b1, 1'b0, '0);
            chk("resume_valid", 64'(s_valid), 64'(1));
        end

        // Redirect while buffered and a read is in flight.
        do_reset();
        repeat (2) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0103);
        step(1'b0, 1'b0, '0);
        chk("redir_valid1", 64'(s_valid), 64'(0));
        chk("redir_issue", 64'(s_en), 64'(1));
        chk("redir_addr", 64'(s_addr), 64'(32'h40));
        step(1'b0, 1'b0, '0);
        chk("redir_valid2", 64'(s_valid), 64'(0));
        step(1'b0, 1'b0, '0);
        chk("redir_valid3", 64'(s_valid), 64'(1));
        chk("redir_pc", 64'(s_pc), 64'(32'h100));
        chk("redir_instr", 64'(s_instr), 64'(32'hA000_0040));

        // Redirect in the same cycle decode pops PC 0x20.
        do_reset();
        repeat (10) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0200);
        chk("rpop_valid", 64'(s_valid), 64'(1));
        chk("rpop_pc", 64'(s_pc), 64'(32'h20));
        repeat (2) begin
            step(1'b1, 1'b0, '0);
            chk("rpop_gap", 64'(s_valid), 64'(0));
        end
        step(1'b1, 1'b0, '0);
        chk("rpop_next", 64'(s_pc), 64'(32'h200));

        // PC and ROM address wrap-around.
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0);
        chk("wrap_addr_top", 64'(s_addr), 64'(10'h3FF));
        step(1'b1, 1'b0, '0);
        chk("wrap_addr_zero", 64'(s_addr), 64'(0));
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        chk("wrap_pc", 64'(s_pc), 64'(0));
        step(1'b1, 1'b1, 32'h0000_1000);
        step(1'b1, 1'b0, '0);
        chk("addr_alias", 64'(s_addr), 64'(0));
        repeat (4) step(1'b1, 1'b0, '0);

        // Asynchronous reset mid-stream, then restart.
        chk("mid_valid_before", 64'(bus.instr_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        do_reset();
        measure_latency("restart");

        // Random ready/redirect traffic against the stream model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step(rdy, rv, rpc);
        end
        chk("max_gap", 64'(max_gap), 64'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
